// File: rtl/l2_per_timeout_bridge.sv
// Single-outstanding bridge on the L2 PER port: forwards one request downstream and
// converts a missing response into an error response after a programmable timeout.
module l2_per_timeout_bridge #(
  parameter int                  ADDR_WIDTH     = 32,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  BE_WIDTH       = DATA_WIDTH / 8,
  parameter int                  AUX_WIDTH      = 4,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter int                  CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1),
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA    = 32'hBADACCE5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  timeout_en_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [AUX_WIDTH-1:0]  aux_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic [AUX_WIDTH-1:0]  r_aux_o,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] add_o,
  output logic                  wen_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic [AUX_WIDTH-1:0]  aux_o,
  input  logic                  gnt_i,
  input  logic                  r_valid_i,
  input  logic [DATA_WIDTH-1:0] r_rdata_i,
  input  logic                  r_opc_i,
  input  logic [AUX_WIDTH-1:0]  r_aux_i,
  output logic                  timeout_o,
  output logic [7:0]            timeout_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, ERR_RESP, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMER_ONE  = CNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   timer, timer_nxt;
  logic [AUX_WIDTH-1:0]   sampled_aux, sampled_aux_nxt;
  logic                   handshake;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign add_o     = add_i;
  assign wen_o     = wen_i;
  assign wdata_o   = wdata_i;
  assign be_o      = be_i;
  assign aux_o     = aux_i;
  assign handshake = req_i & gnt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      sampled_aux   <= '0;
      timeout_cnt_o <= 8'd0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      sampled_aux <= sampled_aux_nxt;
      if (state == ERR_RESP)
        timeout_cnt_o <= sat_inc8(timeout_cnt_o);
    end
  end

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    sampled_aux_nxt = sampled_aux;
    req_o           = 1'b0;
    gnt_o           = 1'b0;
    r_valid_o       = 1'b0;
    r_rdata_o       = '0;
    r_opc_o         = 1'b0;
    r_aux_o         = '0;
    timeout_o       = 1'b0;
    case (state)
      IDLE: begin
        req_o = req_i;
        gnt_o = gnt_i;
        if (handshake) begin
          sampled_aux_nxt = aux_i;
          timer_nxt       = '0;
          state_nxt       = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        r_valid_o = r_valid_i;
        r_rdata_o = r_rdata_i;
        r_opc_o   = r_opc_i;
        r_aux_o   = r_aux_i;
        // A real response always beats expiry in the same cycle
        if (r_valid_i) begin
          req_o = req_i;
          gnt_o = gnt_i;
          if (handshake) begin
            sampled_aux_nxt = aux_i;
            timer_nxt       = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout_en_i) begin
          if (timer == TIMER_LAST)
            state_nxt = ERR_RESP;
          else
            timer_nxt = timer + TIMER_ONE;
        end
      end
      ERR_RESP: begin
        r_valid_o = 1'b1;
        r_opc_o   = 1'b1;
        r_rdata_o = ERR_RDATA;
        r_aux_o   = sampled_aux;
        timeout_o = 1'b1;
        state_nxt = r_valid_i ? IDLE : DRAIN;
      end
      DRAIN: begin
        // Upstream stays stalled until the late slave response is swallowed
        if (r_valid_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_per_timeout_bridge.sv
// Bench for l2_per_timeout_bridge: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_l2_per_timeout_bridge;

  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timeout_en_i;
  logic        req_i;
  logic [31:0] add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [3:0]  aux_i;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic [3:0]  r_aux_o;
  logic        req_o;
  logic [31:0] add_o;
  logic        wen_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [3:0]  aux_o;
  logic        gnt_i;
  logic        r_valid_i;
  logic [31:0] r_rdata_i;
  logic        r_opc_i;
  logic [3:0]  r_aux_i;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;

  int tests = 0;
  int fails = 0;

  // Reference model: one outstanding transaction, counted in enabled idle-wait cycles
  bit       m_busy, m_err, m_drain;
  int       m_elapsed, m_cnt;
  logic [3:0] m_aux;

  always #5 clk = ~clk;

  l2_per_timeout_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .timeout_en_i(timeout_en_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .aux_i(aux_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .r_aux_o(r_aux_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o), .aux_o(aux_o),
    .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i), .r_aux_i(r_aux_i),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_drain = 0; m_elapsed = 0; m_cnt = 0; m_aux = '0;
  endtask

  // Settle combinational outputs and compare them with the model's view of this cycle
  task automatic look();
    logic e_req, e_gnt, e_rv, e_to;
    logic [31:0] e_rd;
    logic e_opc;
    logic [3:0] e_aux;
    #2;
    e_req = 0; e_gnt = 0; e_rv = 0; e_to = 0; e_rd = '0; e_opc = 0; e_aux = '0;
    if (m_err) begin
      e_rv = 1; e_opc = 1; e_rd = ERR; e_aux = m_aux; e_to = 1;
    end else if (m_drain) begin
      e_rv = 0;
    end else if (m_busy) begin
      e_rv = r_valid_i; e_rd = r_rdata_i; e_opc = r_opc_i; e_aux = r_aux_i;
      if (r_valid_i) begin e_req = req_i; e_gnt = gnt_i; end
    end else begin
      e_req = req_i; e_gnt = gnt_i;
    end
    chk("req_o", 32'(req_o), 32'(e_req));
    chk("gnt_o", 32'(gnt_o), 32'(e_gnt));
    chk("r_valid_o", 32'(r_valid_o), 32'(e_rv));
    chk("timeout_o", 32'(timeout_o), 32'(e_to));
    chk("timeout_cnt_o", 32'(timeout_cnt_o), 32'(m_cnt));
    chk("add_o", add_o, add_i);
    chk("wdata_o", wdata_o, wdata_i);
    if (e_rv) begin
      chk("r_rdata_o", r_rdata_o, e_rd);
      chk("r_opc_o", 32'(r_opc_o), 32'(e_opc));
      chk("r_aux_o", 32'(r_aux_o), 32'(e_aux));
    end
  endtask

  task automatic tick();
    bool_upd: begin end
    @(posedge clk);
    if (rst_n) begin
      if (m_err) begin
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_err   = 0;
        m_drain = !r_valid_i;
      end else if (m_drain) begin
        if (r_valid_i) m_drain = 0;
      end else if (m_busy) begin
        if (r_valid_i) begin
          if (req_i && gnt_i) begin m_aux = aux_i; m_elapsed = 0; end
          else m_busy = 0;
        end else if (timeout_en_i) begin
          m_elapsed++;
          if (m_elapsed == TO) begin m_busy = 0; m_err = 1; end
        end
      end else if (req_i && gnt_i) begin
        m_busy = 1; m_elapsed = 0; m_aux = aux_i;
      end
    end
    #1;
  endtask

  task automatic cyc();
    look();
    tick();
  endtask

  initial begin
    int n;
    rst_n = 0; timeout_en_i = 1; req_i = 1; gnt_i = 1; add_i = 32'h10; wen_i = 1;
    wdata_i = 32'h55; be_i = 4'hF; aux_i = 4'h3; r_valid_i = 0; r_rdata_i = '0;
    r_opc_i = 0; r_aux_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_valid", 32'(r_valid_o), 32'd0);
    chk("rst_rdata", r_rdata_o, 32'd0);
    chk("rst_opc", 32'(r_opc_o), 32'd0);
    chk("rst_cnt", 32'(timeout_cnt_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_req_track", 32'(req_o), 32'd1);
    chk("rst_gnt_track", 32'(gnt_o), 32'd1);
    req_i = 0; gnt_i = 0;
    rst_n = 1;
    cyc();

    // 1: simple read, response 3 cycles after grant
    req_i = 1; gnt_i = 1; wen_i = 1; add_i = 32'h1A10_0000; aux_i = 4'h5;
    look(); chk("t1_gnt", 32'(gnt_o), 32'd1); tick();
    req_i = 0; gnt_i = 0;
    cyc(); cyc();
    r_valid_i = 1; r_rdata_i = 32'h1234; r_aux_i = 4'h5; r_opc_i = 0;
    look();
    chk("t1_rvalid", 32'(r_valid_o), 32'd1);
    chk("t1_rdata", r_rdata_o, 32'h1234);
    chk("t1_aux", 32'(r_aux_o), 32'h5);
    chk("t1_opc", 32'(r_opc_o), 32'd0);
    chk("t1_timeout", 32'(timeout_o), 32'd0);
    tick();
    r_valid_i = 0;
    cyc();

    // 2: back-to-back request granted in the response cycle
    req_i = 1; gnt_i = 1; aux_i = 4'h6; cyc();
    req_i = 0; gnt_i = 0; cyc();
    req_i = 1; gnt_i = 1; aux_i = 4'h7; r_valid_i = 1; r_rdata_i = 32'hAAAA; r_aux_i = 4'h6;
    look();
    chk("t2_gnt", 32'(gnt_o), 32'd1);
    chk("t2_rvalid1", 32'(r_valid_o), 32'd1);
    tick();
    req_i = 0; gnt_i = 0; r_valid_i = 0;
    look(); chk("t2_stall_gnt", 32'(gnt_o), 32'd0); tick();
    r_valid_i = 1; r_rdata_i = 32'hBBBB; r_aux_i = 4'h7;
    look(); chk("t2_rdata2", r_rdata_o, 32'hBBBB); tick();
    r_valid_i = 0;
    cyc();

    // 3: no response -> error exactly TO+1 cycles after grant
    req_i = 1; gnt_i = 1; aux_i = 4'hA; cyc();
    req_i = 0; gnt_i = 0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      look();
      if (r_valid_o) begin n = k; break; end
      tick();
    end
    chk("t3_latency", 32'(n), 32'(TO + 1));
    chk("t3_opc", 32'(r_opc_o), 32'd1);
    chk("t3_rdata", r_rdata_o, ERR);
    chk("t3_aux", 32'(r_aux_o), 32'hA);
    chk("t3_timeout", 32'(timeout_o), 32'd1);
    tick();
    chk("t3_cnt", 32'(timeout_cnt_o), 32'd1);

    // 4: drain with late response, upstream stalled meanwhile
    req_i = 1; gnt_i = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) r_valid_i = 1;
      look();
      chk("t4_drain_gnt", 32'(gnt_o), 32'd0);
      chk("t4_drain_rvalid", 32'(r_valid_o), 32'd0);
      tick();
    end
    r_valid_i = 0; aux_i = 4'h2;
    look(); chk("t4_next_gnt", 32'(gnt_o), 32'd1); tick();
    req_i = 0; gnt_i = 0;
    r_valid_i = 1; cyc(); r_valid_i = 0;

    // 5: response lands in the expiry cycle
    req_i = 1; gnt_i = 1; aux_i = 4'h9; cyc();
    req_i = 0; gnt_i = 0;
    repeat (TO - 1) cyc();
    r_valid_i = 1; r_rdata_i = 32'hC0DE; r_opc_i = 0; r_aux_i = 4'h9;
    look();
    chk("t5_opc", 32'(r_opc_o), 32'd0);
    chk("t5_rdata", r_rdata_o, 32'hC0DE);
    chk("t5_timeout", 32'(timeout_o), 32'd0);
    tick();
    r_valid_i = 0;
    look(); chk("t5_cnt", 32'(timeout_cnt_o), 32'd1); tick();

    // 6: reset during WAIT_RESP, then a stray response
    req_i = 1; gnt_i = 1; cyc();
    req_i = 0; gnt_i = 0; cyc(); cyc();
    rst_n = 0;
    #1;
    model_reset();
    chk("t6_rst_cnt", 32'(timeout_cnt_o), 32'd0);
    chk("t6_rst_rvalid", 32'(r_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    r_valid_i = 1; r_rdata_i = 32'hDEAD;
    look(); chk("t6_stray", 32'(r_valid_o), 32'd0); tick();
    r_valid_i = 0;
    look(); chk("t6_idle_gnt", 32'(gnt_o), 32'(gnt_i)); tick();

    // Randomized traffic including timer freeze via timeout_en_i
    for (int k = 0; k < 3000; k++) begin
      timeout_en_i = ($urandom_range(0, 99) < 85);
      req_i     = 1'($urandom);
      gnt_i     = 1'($urandom);
      add_i     = $urandom;
      wdata_i   = $urandom;
      wen_i     = 1'($urandom);
      be_i      = 4'($urandom);
      aux_i     = 4'($urandom);
      r_valid_i = ($urandom_range(0, 19) == 0);
      r_rdata_i = $urandom;
      r_opc_i   = 1'($urandom);
      r_aux_i   = 4'($urandom);
      cyc();
    end

    // Return to IDLE, then saturate the timeout counter
    timeout_en_i = 1; req_i = 0; gnt_i = 0; r_valid_i = 1;
    repeat (3) cyc();
    r_valid_i = 0;
    for (int k = 0; k < 300; k++) begin
      req_i = 1; gnt_i = 1; aux_i = 4'($urandom); cyc();
      req_i = 0; gnt_i = 0;
      repeat (TO) cyc();
      r_valid_i = 1; cyc(); r_valid_i = 0;
    end
    look();
    chk("t6_sat_cnt", 32'(timeout_cnt_o), 32'd255);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
